// File: rtl/ipm_dist_fifo_pkg.sv
// Shared constants and parameter helpers for the single-clock distributed-RAM FIFO.
package ipm_dist_fifo_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    // Occupancy needs one extra bit so that a completely full FIFO (DEPTH words) is representable.
    function automatic int level_width(input int addr_width);
        return addr_width + 1;
    endfunction

    function automatic bit addr_width_ok(input int addr_width);
        return (addr_width >= 4) && (addr_width <= 10);
    endfunction

    function automatic bit data_width_ok(input int data_width);
        return (data_width >= 1) && (data_width <= 256);
    endfunction

endpackage

// File: rtl/ipm_distributed_sdpram_sync.sv
// Single-clock simple dual-port distributed RAM: synchronous write, asynchronous read.
module ipm_distributed_sdpram_sync #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Storage is deliberately never reset so it maps onto LUT RAM.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ipm_distributed_fifo_sync_fwft.sv
// Single-clock FIFO on distributed RAM with optional first-word-fall-through output,
// programmable almost-full/empty thresholds, occupancy count and overflow/underflow pulses.
module ipm_distributed_fifo_sync_fwft
    import ipm_dist_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int FWFT       = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    output logic                  full,
    output logic                  almost_full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  almost_empty,
    input  logic [ADDR_WIDTH:0]   af_thresh,
    input  logic [ADDR_WIDTH:0]   ae_thresh,
    output logic [ADDR_WIDTH:0]   water_level,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int              LW        = level_width(ADDR_WIDTH);
    localparam int              DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [LW-1:0]   DEPTH_LVL = LW'(DEPTH);
    localparam bit              IS_FWFT   = (FWFT == FIFO_FWFT);

    if (!addr_width_ok(ADDR_WIDTH) || !data_width_ok(DATA_WIDTH) ||
        (FWFT != FIFO_STD && FWFT != FIFO_FWFT)) begin : g_param_check
        $error("ipm_distributed_fifo_sync_fwft: illegal parameter set");
    end

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic [LW-1:0]         ram_cnt;
    logic                  out_vld_q, out_vld_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  af_q, af_d;
    logic                  ae_q, ae_d;
    logic                  ovf_q, unf_q;
    logic                  wr_acc, rd_acc, ram_rd;

    assign wr_acc  = wr_en & ~full_q;
    assign rd_acc  = rd_en & ~empty_q;
    // Words still sitting in RAM; in FWFT mode the output register holds one counted word.
    assign ram_cnt = level_q - LW'(out_vld_q);
    assign ram_rd  = IS_FWFT ? ((~out_vld_q | rd_acc) & (ram_cnt != '0)) : rd_acc;

    ipm_distributed_sdpram_sync #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        wr_ptr_d  = wr_ptr_q + ADDR_WIDTH'(wr_acc);
        rd_ptr_d  = rd_ptr_q + ADDR_WIDTH'(ram_rd);
        level_d   = level_q;
        if (wr_acc && !rd_acc) begin
            level_d = level_q + LW'(1);
        end else if (rd_acc && !wr_acc) begin
            level_d = level_q - LW'(1);
        end
        rd_data_d = ram_rd ? ram_rdata : rd_data_q;
        out_vld_d = IS_FWFT ? (ram_rd | (out_vld_q & ~rd_acc)) : 1'b0;
        empty_d   = IS_FWFT ? ~out_vld_d : (level_d == '0);
        full_d    = (level_d == DEPTH_LVL);
        af_d      = (level_d >= af_thresh);
        ae_d      = (level_d <= ae_thresh);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            out_vld_q <= 1'b0;
            rd_data_q <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            af_q      <= 1'b0;
            ae_q      <= 1'b1;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            out_vld_q <= out_vld_d;
            rd_data_q <= rd_data_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            af_q      <= af_d;
            ae_q      <= ae_d;
            ovf_q     <= wr_en & full_q;
            unf_q     <= rd_en & empty_q;
        end
    end

    assign full         = full_q;
    assign almost_full  = af_q;
    assign empty        = empty_q;
    assign almost_empty = ae_q;
    assign rd_data      = rd_data_q;
    assign water_level  = level_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule
